// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the imem/dmem to single memory port arbiter.
// Owner state encodings, requester IDs and default bus widths.
package core_mem_arbiter_pkg;

    localparam int unsigned ARB_AW = 64;
    localparam int unsigned ARB_DW = 64;
    localparam int unsigned ARB_SW = ARB_DW / 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_D = 2'd1,
        ARB_OWN_I = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_ID_I = 1'b0,
        ARB_ID_D = 1'b1
    } arb_id_e;

    // Lock state that corresponds to a given requester.
    function automatic arb_state_e arb_own_state(input arb_id_e id);
        return (id == ARB_ID_D) ? ARB_OWN_D : ARB_OWN_I;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_sel.sv
// Combinational winner select between fetch and LSU requests.
// CORE_MEM_ARB_FIXED_PRIO_EN: dmem always wins a tie and no history input exists.
module core_mem_arbiter_sel
    import core_mem_arbiter_pkg::*;
(
    input  logic    i_imem_req,
    input  logic    i_dmem_req,
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
    input  arb_id_e i_last,
`endif
    output logic    o_valid,
    output arb_id_e o_winner
);

    always_comb begin
        o_valid  = i_imem_req | i_dmem_req;
        o_winner = ARB_ID_D;
        if (i_imem_req && !i_dmem_req) begin
            o_winner = ARB_ID_I;
        end else if (i_imem_req && i_dmem_req) begin
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
            o_winner = ARB_ID_D;
`else
            // Tie goes to whichever requester was not served last.
            o_winner = (i_last == ARB_ID_D) ? ARB_ID_I : ARB_ID_D;
`endif
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one req/gnt memory port between fetch (imem) and LSU (dmem), one transaction at a time.
// CORE_MEM_ARB_FIXED_PRIO_EN selects fixed dmem priority; default is round-robin.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW,
    parameter int unsigned SW = DW / 8
) (
    input  logic          g_clk,
    input  logic          g_reset,

    input  logic          imem_req,
    input  logic [AW-1:0] imem_addr,
    output logic          imem_gnt,
    output logic          imem_err,
    output logic [DW-1:0] imem_rdata,

    input  logic          dmem_req,
    input  logic [AW-1:0] dmem_addr,
    input  logic          dmem_wen,
    input  logic [SW-1:0] dmem_strb,
    input  logic [DW-1:0] dmem_wdata,
    output logic          dmem_gnt,
    output logic          dmem_err,
    output logic [DW-1:0] dmem_rdata,

    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [SW-1:0] mem_strb,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_err,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e r_state;
    logic       w_sel_valid;
    arb_id_e    w_sel_id;
    logic       w_own_valid;
    arb_id_e    w_own_id;
    logic       w_own_d;
    logic       w_own_i;

`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
    arb_id_e    r_last;
`endif

    core_mem_arbiter_sel u_sel (
        .i_imem_req (imem_req),
        .i_dmem_req (dmem_req),
`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
        .i_last     (r_last),
`endif
        .o_valid    (w_sel_valid),
        .o_winner   (w_sel_id)
    );

    // Current owner: the lock holder, or the same-cycle winner when idle.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_id    = w_sel_id;
        case (r_state)
            ARB_IDLE: begin
                w_own_valid = w_sel_valid;
                w_own_id    = w_sel_id;
            end
            ARB_OWN_D: begin
                w_own_valid = 1'b1;
                w_own_id    = ARB_ID_D;
            end
            ARB_OWN_I: begin
                w_own_valid = 1'b1;
                w_own_id    = ARB_ID_I;
            end
            default: begin
                w_own_valid = 1'b0;
            end
        endcase
        // Reset silences the port immediately, even with requests still raised.
        if (g_reset) begin
            w_own_valid = 1'b0;
        end
    end

    assign w_own_d = w_own_valid && (w_own_id == ARB_ID_D);
    assign w_own_i = w_own_valid && (w_own_id == ARB_ID_I);

    // Request path: owner payload forwarded, everything zero otherwise.
    always_comb begin
        mem_req   = w_own_valid;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_wdata = '0;
        if (w_own_d) begin
            mem_addr  = dmem_addr;
            mem_wen   = dmem_wen;
            mem_strb  = dmem_strb;
            mem_wdata = dmem_wdata;
        end else if (w_own_i) begin
            mem_addr  = imem_addr;
        end
    end

    // Response path: only the owner sees gnt/err/rdata.
    always_comb begin
        imem_gnt   = w_own_i & mem_gnt;
        imem_err   = w_own_i & mem_err;
        imem_rdata = w_own_i ? mem_rdata : '0;
        dmem_gnt   = w_own_d & mem_gnt;
        dmem_err   = w_own_d & mem_err;
        dmem_rdata = w_own_d ? mem_rdata : '0;
    end

    // Lock FSM: a grant always returns to idle so the next arbitration is a fresh cycle.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= ARB_IDLE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_sel_valid && !mem_gnt) begin
                        r_state <= arb_own_state(w_sel_id);
                    end
                end
                ARB_OWN_D, ARB_OWN_I: begin
                    if (mem_gnt) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifndef CORE_MEM_ARB_FIXED_PRIO_EN
    // Round-robin history; starts at imem so dmem wins the first tie.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_last <= ARB_ID_I;
        end else if (w_own_valid && mem_gnt) begin
            r_last <= w_own_id;
        end
    end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus randomized traffic
// compared against an owner/last-served reference model.
module tb_core_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    logic          g_clk = 1'b0;
    logic          g_reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_err;
    logic [DW-1:0] imem_rdata;
    logic          dmem_req;
    logic [AW-1:0] dmem_addr;
    logic          dmem_wen;
    logic [SW-1:0] dmem_strb;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_err;
    logic [DW-1:0] dmem_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_err;
    logic [DW-1:0] mem_rdata;

    always #5 g_clk = ~g_clk;

    core_mem_arbiter dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_err    (mem_err),
        .mem_rdata  (mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = nobody, 1 = imem, 2 = dmem.
    int   m_owner = 0;
    int   m_last  = 1;
    logic e_ig    = 1'b0;
    logic e_dg    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_who();
        if (g_reset) return 0;
        if (m_owner != 0) return m_owner;
        if (imem_req && dmem_req) begin
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
            return 2;
`else
            return (m_last == 1) ? 2 : 1;
`endif
        end
        if (dmem_req) return 2;
        if (imem_req) return 1;
        return 0;
    endfunction

    // Compare every output against the model for the current inputs, then advance the model
    // to the state it holds after the next rising edge.
    task automatic check_cycle(input string tag);
        int who;
        who = model_who();
        chk({tag, ".mem_req"},    64'(mem_req),   64'(who != 0));
        chk({tag, ".mem_addr"},   mem_addr,       (who == 2) ? dmem_addr : (who == 1) ? imem_addr : 64'd0);
        chk({tag, ".mem_wen"},    64'(mem_wen),   64'((who == 2) && dmem_wen));
        chk({tag, ".mem_strb"},   64'(mem_strb),  (who == 2) ? 64'(dmem_strb) : 64'd0);
        chk({tag, ".mem_wdata"},  mem_wdata,      (who == 2) ? dmem_wdata : 64'd0);
        chk({tag, ".imem_gnt"},   64'(imem_gnt),  64'((who == 1) && mem_gnt));
        chk({tag, ".imem_err"},   64'(imem_err),  64'((who == 1) && mem_err));
        chk({tag, ".imem_rdata"}, imem_rdata,     (who == 1) ? mem_rdata : 64'd0);
        chk({tag, ".dmem_gnt"},   64'(dmem_gnt),  64'((who == 2) && mem_gnt));
        chk({tag, ".dmem_err"},   64'(dmem_err),  64'((who == 2) && mem_err));
        chk({tag, ".dmem_rdata"}, dmem_rdata,     (who == 2) ? mem_rdata : 64'd0);
        e_ig = (who == 1) && mem_gnt;
        e_dg = (who == 2) && mem_gnt;
        if (who != 0) begin
            if (mem_gnt) begin
                m_last  = who;
                m_owner = 0;
            end else begin
                m_owner = who;
            end
        end
    endtask

    // Called at a falling edge with inputs already set.
    task automatic step(input string tag);
        #1;
        check_cycle(tag);
        @(negedge g_clk);
    endtask

    task automatic clear_inputs();
        imem_req   = 1'b0;
        imem_addr  = '0;
        dmem_req   = 1'b0;
        dmem_addr  = '0;
        dmem_wen   = 1'b0;
        dmem_strb  = '0;
        dmem_wdata = '0;
        mem_gnt    = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        m_owner = 0;
        m_last  = 1;
        #1;
        check_cycle("rst_pulse");
        @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    int seq[$];
    int exp_seq[4];

    initial begin
        clear_inputs();
        g_reset = 1'b1;
`ifdef CORE_MEM_ARB_FIXED_PRIO_EN
        exp_seq = '{2, 2, 2, 2};
`else
        exp_seq = '{2, 1, 2, 1};
`endif

        // Reset state, with junk requests raised to prove reset gating.
        @(negedge g_clk);
        imem_req  = 1'b1;
        imem_addr = 64'hABCD;
        dmem_req  = 1'b1;
        dmem_addr = 64'h1234;
        #1;
        check_cycle("reset");
        chk("reset.mem_req", 64'(mem_req), 64'd0);
        @(negedge g_clk);
        g_reset = 1'b0;
        clear_inputs();

        // Lone dmem write, granted in its third cycle.
        dmem_req   = 1'b1;
        dmem_addr  = 64'h1000;
        dmem_wen   = 1'b1;
        dmem_strb  = 8'hFF;
        dmem_wdata = 64'h1234_5678_9ABC_DEF0;
        for (int c = 0; c < 3; c++) begin
            mem_gnt = (c == 2);
            #1;
            check_cycle("lone_d");
            chk("lone_d.addr", mem_addr, 64'h1000);
            chk("lone_d.wen",  64'(mem_wen), 64'd1);
            chk("lone_d.dgnt", 64'(dmem_gnt), 64'(c == 2));
            chk("lone_d.ignt", 64'(imem_gnt), 64'd0);
            @(negedge g_clk);
        end
        clear_inputs();
        step("idle");

        // Continuous contention with a grant every cycle from a fresh reset.
        do_reset();
        imem_req  = 1'b1;
        imem_addr = 64'h0000_0000_0000_2000;
        dmem_req  = 1'b1;
        dmem_addr = 64'h0000_0000_0000_8000;
        mem_gnt   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_cycle("contend");
            if (dmem_gnt && !imem_gnt)      seq.push_back(2);
            else if (imem_gnt && !dmem_gnt) seq.push_back(1);
            else                            seq.push_back(0);
            @(negedge g_clk);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("order[%0d]", k), 64'(seq[k]), 64'(exp_seq[k]));
        end
        clear_inputs();
        step("idle2");

        // imem holds the port for 5 cycles while dmem waits from cycle 1.
        imem_req  = 1'b1;
        imem_addr = 64'h2000;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                dmem_req  = 1'b1;
                dmem_addr = 64'h3000;
                dmem_wen  = 1'b0;
            end
            mem_gnt = (c == 4);
            #1;
            check_cycle("hold_i");
            chk("hold_i.addr", mem_addr, 64'h2000);
            chk("hold_i.dgnt", 64'(dmem_gnt), 64'd0);
            chk("hold_i.ignt", 64'(imem_gnt), 64'(c == 4));
            @(negedge g_clk);
        end
        imem_req = 1'b0;
        mem_gnt  = 1'b0;
        #1;
        check_cycle("then_d");
        chk("then_d.addr", mem_addr, 64'h3000);
        @(negedge g_clk);
        mem_gnt = 1'b1;
        #1;
        check_cycle("then_d_gnt");
        chk("then_d_gnt.dgnt", 64'(dmem_gnt), 64'd1);
        @(negedge g_clk);
        clear_inputs();

        // Error response routed to imem only; also a same-cycle grant from idle.
        imem_req  = 1'b1;
        imem_addr = 64'h4000;
        mem_gnt   = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = 64'hDEAD;
        #1;
        check_cycle("err_i");
        chk("err_i.ierr",   64'(imem_err), 64'd1);
        chk("err_i.irdata", imem_rdata, 64'hDEAD);
        chk("err_i.derr",   64'(dmem_err), 64'd0);
        @(negedge g_clk);
        clear_inputs();

        // Same-cycle grant in idle, then a new request forwarded immediately.
        dmem_req  = 1'b1;
        dmem_addr = 64'h5000;
        mem_gnt   = 1'b1;
        #1;
        check_cycle("fast_d");
        chk("fast_d.dgnt", 64'(dmem_gnt), 64'd1);
        @(negedge g_clk);
        dmem_addr = 64'h5008;
        mem_gnt   = 1'b0;
        #1;
        check_cycle("fast_next");
        chk("fast_next.req",  64'(mem_req), 64'd1);
        chk("fast_next.addr", mem_addr, 64'h5008);
        @(negedge g_clk);
        mem_gnt = 1'b1;
        step("fast_done");
        clear_inputs();

        // Reset while dmem owns the port.
        dmem_req  = 1'b1;
        dmem_addr = 64'h6000;
        step("own_d");
        #1;
        check_cycle("own_d_hold");
        chk("own_d_hold.req", 64'(mem_req), 64'd1);
        #1;
        g_reset = 1'b1;
        m_owner = 0;
        m_last  = 1;
        #1;
        chk("rst_async.req", 64'(mem_req), 64'd0);
        check_cycle("rst_async");
        @(negedge g_clk);
        g_reset = 1'b0;
        #1;
        check_cycle("rereq");
        chk("rereq.req",  64'(mem_req), 64'd1);
        chk("rereq.addr", mem_addr, 64'h6000);
        @(negedge g_clk);
        mem_gnt = 1'b1;
        step("rereq_gnt");
        clear_inputs();
        step("idle3");

        // Randomized traffic; requesters hold their payload until granted.
        for (int c = 0; c < 400; c++) begin
            if (imem_req && !e_ig) begin
                if ($urandom_range(0, 31) == 0) imem_req = 1'b0;
            end else begin
                imem_req  = ($urandom_range(0, 1) == 1);
                imem_addr = {$urandom, $urandom};
            end
            if (dmem_req && !e_dg) begin
                if ($urandom_range(0, 31) == 0) dmem_req = 1'b0;
            end else begin
                dmem_req   = ($urandom_range(0, 1) == 1);
                dmem_addr  = {$urandom, $urandom};
                dmem_wen   = ($urandom_range(0, 1) == 1);
                dmem_strb  = 8'($urandom);
                dmem_wdata = {$urandom, $urandom};
            end
            mem_gnt   = ($urandom_range(0, 2) == 0);
            mem_err   = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Two-requester arbiter that shares a single memory port between instruction fetch (imem) and the execute-stage LSU (dmem). It uses the core's req/gnt memory handshake on every side. It keeps at most one transaction outstanding downstream and locks onto the granted requester until the memory returns `gnt`. It sits between the pipeline's `imem_*` / `dmem_*` buses and the single-port memory interface at the core boundary.

## Interface
- `AW`, 64: address width.
- `DW`, 64: data width.
- `SW`, `DW/8`: write strobe width.
- `g_clk` in 1: global clock.
- `g_reset` in 1: global reset, asynchronous, active-high.
- `imem_req` in 1: fetch request; held with its payload until `imem_gnt`.
- `imem_addr` in AW: fetch address.
- `imem_gnt` out 1: one-cycle fetch response valid.
- `imem_err` out 1: fetch response error; valid with `imem_gnt`.
- `imem_rdata` out DW: fetch read data; valid with `imem_gnt`.
- `dmem_req` in 1: LSU request; held with its payload until `dmem_gnt`.
- `dmem_addr` in AW: LSU address.
- `dmem_wen` in 1: LSU write enable.
- `dmem_strb` in SW: LSU write strobe.
- `dmem_wdata` in DW: LSU write data.
- `dmem_gnt` out 1: one-cycle LSU response valid.
- `dmem_err` out 1: LSU response error.
- `dmem_rdata` out DW: LSU read data.
- `mem_req`, `mem_addr`, `mem_wen`, `mem_strb`, `mem_wdata` out 1/AW/1/SW/DW: shared port request.
- `mem_gnt`, `mem_err`, `mem_rdata` in 1/1/DW: shared port response.

## Operation
- State machine states:
  - IDLE: no owner.
  - OWN_D: LSU owns the port.
  - OWN_I: fetch owns the port.
- IDLE, selection:
  - Winner is chosen combinationally from `imem_req` and `dmem_req`.
  - The winner's request is driven onto `mem_*` in the same cycle (zero added latency).
  - If `mem_gnt` arrives that cycle, stay in IDLE. Otherwise move to OWN_D or OWN_I.
- OWN_x:
  - `mem_req` = 1 and the payload comes from requester x.
  - The other requester sees no `gnt` and stalls.
  - On `mem_gnt`, go to IDLE.
  - Arbitration for the next transaction starts in the cycle after `gnt`; no back-to-back forwarding in the `gnt` cycle.
- Round-robin (default):
  - A `last` register records the most recently granted requester.
  - When both requesters ask in IDLE, the one that is not `last` wins.
  - `last` updates on every `mem_gnt`.
  - Reset value of `last` = imem, so dmem wins the first tie.
- Response routing:
  - `mem_gnt`, `mem_err` and `mem_rdata` go only to the current owner.
  - In IDLE the owner is the same-cycle winner.
  - The non-owner's `gnt` = 0, `err` = 0, `rdata` = 0.
- When not requesting, `mem_addr`, `mem_wen`, `mem_strb` and `mem_wdata` are driven to 0. `mem_wen` is always 0 for imem.
- Protocol violation: a requester must not drop `req` while it owns the port. If it does, the arbiter still holds the lock and `mem_req` until `mem_gnt`.
- Reset mid-transaction: the state returns to IDLE immediately and the lock is abandoned. Requesters must re-issue after reset.

## Timing
- Reset values:
  - `mem_req` = 0, all `mem_*` payload = 0.
  - All `*_gnt` / `*_err` = 0, all `*_rdata` = 0.
  - State = IDLE.
- Latency: a request is visible on `mem_req` in the cycle it is raised, when the port is free. `gnt` passes through combinationally.
- Simultaneous events in the `gnt` cycle:
  - A new request from the non-owner waits one cycle.
  - The owner's next request is arbitrated against the other requester in the following cycle.
- Fairness: under continuous contention, `mem_gnt` alternates between imem and dmem.
- Worst-case wait under round-robin is one full transaction of the other requester.

## Configuration
- `CORE_MEM_ARB_FIXED_PRIO_EN` defined:
  - dmem always wins a tie.
  - The `last` register is removed.
  - imem can starve under continuous LSU traffic; this is accepted because fetch is stalled anyway while execute holds the pipe.
- Undefined: round-robin as described above.

## Structure
- Add to `core_common.vh`:
  - State encodings `ARB_IDLE`, `ARB_OWN_D`, `ARB_OWN_I` (2-bit).
  - Requester ID constants `ARB_ID_I`, `ARB_ID_D`.
- Sub-module `core_mem_arbiter_sel`: combinational winner select from the two `req` inputs, `last`, and the priority macro. The top level holds the FSM, the `last` register and the muxing.

## Test plan
- Lone dmem request (`dmem_addr`=0x1000, `wen`=1, `strb`=0xFF, `mem_gnt` after 2 cycles):
  - `mem_*` mirrors dmem for 3 cycles.
  - `dmem_gnt` pulses once in cycle 2; `imem_gnt` stays 0.
- Both requesting continuously, `mem_gnt` every cycle:
  - Round-robin: grant order D, I, D, I.
  - `CORE_MEM_ARB_FIXED_PRIO_EN`: D, D, D, D.
- imem owns with `mem_gnt` delayed 4 cycles; dmem raises `req` in cycle 1:
  - `mem_addr` stays on `imem_addr` until `gnt`.
  - dmem is served starting the cycle after.
- `mem_err`=1 with `gnt` on an imem transaction (rdata=0xDEAD): `imem_err`=1, `imem_rdata`=0xDEAD, `dmem_err`=0.
- `g_reset` asserted mid OWN_D (no `gnt`): `mem_req` drops to 0 asynchronously and the state is IDLE. After release, the dmem re-request is forwarded the same cycle.
- Same-cycle `gnt` in IDLE:
  - Single-cycle grant; the state never leaves IDLE.
  - The next request is forwarded the following cycle.
